// File: rtl/hit_arbiter.sv
// hit_arbiter
// Frame-rate scheduler between hit detection and the health datapath.
// Turns level hit flags into one damage transaction per overlap, applies
// block reduction, and walks each player through hitstun and
// invulnerability windows.
//
// Ports:
//   clk, rst                    frame clock, asynchronous active-high reset
//   game_active                 hits accepted only while high; low aborts both FSMs
//   p1/p2_hit_flag [1:0]        00 none, 01 basic, 1x directional
//   p1/p2_blocking              player is blocking (damage - 1, floored at 0)
//   p1/p2_dmg_valid, p1/p2_dmg  damage transaction and amount
//   p1/p2_dmg_ready             health datapath accepts damage
//   p1/p2_stunned               player inputs must be ignored
//   p1/p2_invuln                player is immune
//   trade_count [7:0]           saturating count of simultaneous accepted hits
module hit_arbiter #(
  parameter int unsigned HITSTUN_FRAMES = 12,
  parameter int unsigned INVULN_FRAMES  = 20,
  parameter int unsigned BASIC_DMG      = 1,
  parameter int unsigned DIR_DMG        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_active,
  input  logic [1:0] p1_hit_flag,
  input  logic [1:0] p2_hit_flag,
  input  logic       p1_blocking,
  input  logic       p2_blocking,
  output logic       p1_dmg_valid,
  output logic       p2_dmg_valid,
  output logic [1:0] p1_dmg,
  output logic [1:0] p2_dmg,
  input  logic       p1_dmg_ready,
  input  logic       p2_dmg_ready,
  output logic       p1_stunned,
  output logic       p2_stunned,
  output logic       p1_invuln,
  output logic       p2_invuln,
  output logic [7:0] trade_count
);

  typedef enum logic [1:0] {IDLE, PENDING, STUN, INVULN} state_t;

  localparam logic [7:0] STUN_LOAD = 8'(HITSTUN_FRAMES - 1);
  localparam logic [7:0] INV_LOAD  = 8'(INVULN_FRAMES - 1);
  localparam logic [1:0] BASIC_AMT = 2'(BASIC_DMG);
  localparam logic [1:0] DIR_AMT   = 2'(DIR_DMG);

  state_t     state_q [2];
  state_t     state_d [2];
  logic [7:0] cnt_q   [2];
  logic [7:0] cnt_d   [2];
  logic [1:0] dmg_q   [2];
  logic [1:0] dmg_d   [2];
  logic       prev_q  [2];
  logic [7:0] trade_q;
  logic [7:0] trade_d;

  logic [1:0] flag     [2];
  logic       blocking [2];
  logic       ready    [2];
  logic       new_hit  [2];
  logic [1:0] hit_dmg  [2];
  logic       accept   [2];

  assign flag[0]     = p1_hit_flag;
  assign flag[1]     = p2_hit_flag;
  assign blocking[0] = p1_blocking;
  assign blocking[1] = p2_blocking;
  assign ready[0]    = p1_dmg_ready;
  assign ready[1]    = p2_dmg_ready;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      dmg_d[p]   = dmg_q[p];
      accept[p]  = 1'b0;
      new_hit[p] = (flag[p] != 2'b00) && !prev_q[p];
      hit_dmg[p] = (flag[p] == 2'b01) ? BASIC_AMT : DIR_AMT;
      if (blocking[p] && (hit_dmg[p] != 2'b00)) begin
        hit_dmg[p] = hit_dmg[p] - 2'd1;
      end

      if (!game_active) begin
        state_d[p] = IDLE;
        cnt_d[p]   = '0;
      end else begin
        case (state_q[p])
          IDLE: begin
            if (new_hit[p]) begin
              if (hit_dmg[p] != 2'b00) begin
                state_d[p] = PENDING;
                dmg_d[p]   = hit_dmg[p];
                accept[p]  = 1'b1;
              end else begin
                // Fully blocked hit: immunity window only, no transaction.
                state_d[p] = INVULN;
                cnt_d[p]   = INV_LOAD;
              end
            end
          end
          PENDING: begin
            if (ready[p]) begin
              state_d[p] = STUN;
              cnt_d[p]   = STUN_LOAD;
            end
          end
          STUN: begin
            if (cnt_q[p] == '0) begin
              state_d[p] = INVULN;
              cnt_d[p]   = INV_LOAD;
            end else begin
              cnt_d[p] = cnt_q[p] - 8'd1;
            end
          end
          INVULN: begin
            if (cnt_q[p] == '0) begin
              state_d[p] = IDLE;
            end else begin
              cnt_d[p] = cnt_q[p] - 8'd1;
            end
          end
          default: begin
            state_d[p] = IDLE;
            cnt_d[p]   = '0;
          end
        endcase
      end
    end

    trade_d = trade_q;
    if (accept[0] && accept[1] && (trade_q != '1)) begin
      trade_d = trade_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < 2; p++) begin
        state_q[p] <= IDLE;
        cnt_q[p]   <= '0;
        dmg_q[p]   <= '0;
        prev_q[p]  <= 1'b0;
      end
      trade_q <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
        dmg_q[p]   <= dmg_d[p];
        prev_q[p]  <= (flag[p] != 2'b00);
      end
      trade_q <= trade_d;
    end
  end

  assign p1_dmg_valid = (state_q[0] == PENDING);
  assign p2_dmg_valid = (state_q[1] == PENDING);
  assign p1_dmg       = (state_q[0] == PENDING) ? dmg_q[0] : '0;
  assign p2_dmg       = (state_q[1] == PENDING) ? dmg_q[1] : '0;
  assign p1_stunned   = (state_q[0] == PENDING) || (state_q[0] == STUN);
  assign p2_stunned   = (state_q[1] == PENDING) || (state_q[1] == STUN);
  assign p1_invuln    = (state_q[0] == INVULN);
  assign p2_invuln    = (state_q[1] == INVULN);
  assign trade_count  = trade_q;

endmodule
